// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM encoding and parity types.
package uart_tx_fifo_drain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_drain_bit_timer.sv
// Baud timer: counts 0..N-1 per bit period and strobes o_bit_done on the last cycle.
// N is captured on i_load so mid-frame divider changes wait for the next frame.
module uart_tx_fifo_drain_bit_timer #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic                 i_active,
  input  logic [DIV_WIDTH-1:0] i_baud_div,
  output logic                 o_bit_done
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_last;
  logic [DIV_WIDTH-1:0] w_last;

  // A divider of 0 behaves as 1, i.e. terminal count 0
  assign w_last     = (i_baud_div == '0) ? '0 : i_baud_div - DIV_WIDTH'(1);
  assign o_bit_done = i_active && (r_cnt == r_last);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_last <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_last <= w_last;
    end else if (i_active) begin
      r_cnt <= o_bit_done ? '0 : r_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from the read side of an async FIFO and serialises each as a UART frame
// (start, data LSB first, optional parity, one stop bit) with no gap between frames.
//
// state     | meaning
// ST_IDLE   | line high, waiting for FIFO non-empty
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only when latched par_en is set)
// ST_STOP   | stop bit (high); last cycle may chain straight into the next frame
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_fifo_r_inc,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic [DIV_WIDTH-1:0]  i_baud_div,
  output logic                  o_tx_out,
  output logic                  o_busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BCW-1:0]        r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  w_bit_done;
  logic                  w_load;
  logic                  w_active;

  assign w_active = (r_state != ST_IDLE);
  assign w_load   = !i_fifo_empty &&
                    ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_done));

  uart_tx_fifo_drain_bit_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_bit_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_active   (w_active),
    .i_baud_div (i_baud_div),
    .o_bit_done (w_bit_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_par_en     <= 1'b0;
      r_par_bit    <= 1'b0;
      o_fifo_r_inc <= 1'b0;
      o_tx_out     <= 1'b1;
      o_busy       <= 1'b0;
    end else begin
      o_fifo_r_inc <= 1'b0;
      if (w_load) begin
        // Parity is computed from the whole word up front so the shifter can be consumed
        r_state      <= ST_START;
        r_shift      <= i_fifo_rd_data;
        r_bit_cnt    <= '0;
        r_par_en     <= i_par_en;
        r_par_bit    <= (^i_fifo_rd_data) ^ (i_par_typ == PAR_ODD);
        o_fifo_r_inc <= 1'b1;
        o_tx_out     <= 1'b0;
        o_busy       <= 1'b1;
      end else if (w_bit_done) begin
        case (r_state)
          ST_START: begin
            r_state  <= ST_DATA;
            o_tx_out <= r_shift[0];
          end
          ST_DATA: begin
            if (r_bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              r_state  <= r_par_en ? ST_PARITY : ST_STOP;
              o_tx_out <= r_par_en ? r_par_bit : 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              o_tx_out  <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state  <= ST_STOP;
            o_tx_out <= 1'b1;
          end
          default: begin
            r_state  <= ST_IDLE;
            o_tx_out <= 1'b1;
            o_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
